// File: rtl/sockit_spi_rpk.sv
// Read-path repackager: de-interleaves 3-wire/SPI/dual/quad queue segments
// into a serial bit order and packs them into CDW-bit command words. The
// accumulator and output register together form a two-deep buffer, so the
// queue keeps flowing at one segment per cycle while the command side is ready.
module sockit_spi_rpk #(
  parameter int SDW = 8,
  parameter int CDW = 32,
  parameter int CNW = $clog2(CDW/SDW),
  parameter int CCI = CNW+2,
  parameter int QCI = 4,
  parameter int QDW = 4*SDW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           que_vld,
  input  logic [QCI-1:0] que_ctl,
  input  logic [QDW-1:0] que_dat,
  output logic           que_rdy,
  output logic           cmd_vld,
  output logic [CCI-1:0] cmd_ctl,
  output logic [CDW-1:0] cmd_dat,
  input  logic           cmd_rdy,
  output logic           err
);

  localparam int UN = CDW/SDW;
  localparam logic [CNW+1:0] UNV = (CNW+2)'(UN);
  localparam logic [CNW+1:0] W1  = (CNW+2)'(1);
  localparam logic [CNW+1:0] W2  = (CNW+2)'(2);
  localparam logic [CNW+1:0] W4  = (CNW+2)'(4);

  // accumulator stage
  logic [CDW-1:0] acc_q, acc_d;
  logic [CNW:0]   u_q, u_d;
  logic           new_q, new_d;
  logic           lst_q, lst_d;
  logic           pend_q, pend_d;
  logic           err_q, err_d;
  // output stage
  logic           ov_q, ov_d;
  logic [CCI-1:0] oc_q, oc_d;
  logic [CDW-1:0] od_q, od_d;

  logic [CDW-1:0] seg, acc_nx;
  logic [CNW+1:0] w, sum, u_nx;
  logic           ovf, done, new_nx, out_free;

  assign que_rdy = ~pend_q;
  assign cmd_vld = ov_q;
  assign cmd_ctl = oc_q;
  assign cmd_dat = od_q;
  assign err     = err_q;

  // Segment de-interleave by IO mode; older accumulator bits shift up.
  // Quad shifts in two halves so no single shift reaches the full CDW width.
  always_comb begin
    seg    = '0;
    w      = W1;
    acc_nx = '0;
    case (que_ctl[1:0])
      2'd0: begin
        seg[SDW-1:0] = que_dat[SDW-1:0];
        acc_nx       = (acc_q << SDW) | seg;
      end
      2'd1: begin
        seg[SDW-1:0] = que_dat[2*SDW-1:SDW];
        acc_nx       = (acc_q << SDW) | seg;
      end
      2'd2: begin
        for (int k = 0; k < SDW; k++) begin
          seg[2*k+1] = que_dat[SDW+k];
          seg[2*k]   = que_dat[k];
        end
        w      = W2;
        acc_nx = (acc_q << (2*SDW)) | seg;
      end
      default: begin
        for (int k = 0; k < SDW; k++)
          for (int l = 0; l < 4; l++)
            seg[4*k+l] = que_dat[l*SDW+k];
        w      = W4;
        acc_nx = ((acc_q << (2*SDW)) << (2*SDW)) | seg;
      end
    endcase
  end

  // Unit count with saturation; a word closes when full or on a last segment.
  always_comb begin
    sum      = {1'b0, u_q} + w;
    ovf      = sum > UNV;
    u_nx     = ovf ? UNV : sum;
    done     = (u_nx == UNV) | que_ctl[2];
    new_nx   = (u_q == '0) ? que_ctl[3] : new_q;
    out_free = ~ov_q | cmd_rdy;
  end

  // Next state: pending word moves first; otherwise accept a segment,
  // bypassing straight into the output register when it is free.
  always_comb begin
    acc_d  = acc_q;
    u_d    = u_q;
    new_d  = new_q;
    lst_d  = lst_q;
    pend_d = pend_q;
    err_d  = err_q;
    ov_d   = ov_q;
    oc_d   = oc_q;
    od_d   = od_q;
    if (pend_q) begin
      if (out_free) begin
        ov_d   = 1'b1;
        oc_d   = {new_q, lst_q, CNW'(u_q - 1'b1)};
        od_d   = acc_q;
        pend_d = 1'b0;
        acc_d  = '0;
        u_d    = '0;
        new_d  = 1'b0;
        lst_d  = 1'b0;
      end
    end else if (que_vld) begin
      if (ovf) err_d = 1'b1;
      if (done && out_free) begin
        ov_d  = 1'b1;
        oc_d  = {new_nx, que_ctl[2], CNW'(u_nx - 1'b1)};
        od_d  = acc_nx;
        acc_d = '0;
        u_d   = '0;
        new_d = 1'b0;
        lst_d = 1'b0;
      end else begin
        acc_d  = acc_nx;
        u_d    = u_nx[CNW:0];
        new_d  = new_nx;
        lst_d  = que_ctl[2];
        pend_d = done;
        if (ov_q && cmd_rdy) ov_d = 1'b0;
      end
    end else if (ov_q && cmd_rdy) begin
      ov_d = 1'b0;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      u_q    <= '0;
      new_q  <= 1'b0;
      lst_q  <= 1'b0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
      ov_q   <= 1'b0;
      oc_q   <= '0;
      od_q   <= '0;
    end else begin
      acc_q  <= acc_d;
      u_q    <= u_d;
      new_q  <= new_d;
      lst_q  <= lst_d;
      pend_q <= pend_d;
      err_q  <= err_d;
      ov_q   <= ov_d;
      oc_q   <= oc_d;
      od_q   <= od_d;
    end
  end

endmodule

// File: tb/tb_sockit_spi_rpk.sv
// Bench for sockit_spi_rpk: a unit-queue model predicts every command word,
// a negedge process compares each transfer, err and hold stability, and the
// directed tests pin literal words, flags and timing.
module tb_sockit_spi_rpk;
  localparam int SDW = 8;
  localparam int CDW = 32;
  localparam int UN  = CDW/SDW;

  logic        clk, rst, que_vld, que_rdy, cmd_vld, cmd_rdy, err;
  logic [3:0]  que_ctl, cmd_ctl;
  logic [31:0] que_dat, cmd_dat;

  sockit_spi_rpk #(.SDW(SDW), .CDW(CDW)) dut (
    .clk(clk), .rst(rst), .que_vld(que_vld), .que_ctl(que_ctl),
    .que_dat(que_dat), .que_rdy(que_rdy), .cmd_vld(cmd_vld),
    .cmd_ctl(cmd_ctl), .cmd_dat(cmd_dat), .cmd_rdy(cmd_rdy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0, cyc = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Model: the accumulator is a queue of SDW-bit units, oldest first.
  logic [7:0]  mq[$];
  bit          m_new, m_err;
  logic [31:0] exp_dat[$];
  logic [3:0]  exp_ctl[$];

  function automatic void model_accept(logic [3:0] ctl, logic [31:0] dat);
    logic [7:0]  l [4];
    logic [7:0]  units[$];
    logic [31:0] s, wd;
    for (int i = 0; i < 4; i++) l[i] = dat[i*8 +: 8];
    s = '0;
    case (ctl[1:0])
      2'd0: units.push_back(l[0]);
      2'd1: units.push_back(l[1]);
      2'd2: begin
        for (int k = 0; k < 8; k++)
          for (int j = 0; j < 2; j++) s[2*k+j] = l[j][k];
        units.push_back(s[15:8]); units.push_back(s[7:0]);
      end
      default: begin
        for (int k = 0; k < 8; k++)
          for (int j = 0; j < 4; j++) s[4*k+j] = l[j][k];
        units.push_back(s[31:24]); units.push_back(s[23:16]);
        units.push_back(s[15:8]);  units.push_back(s[7:0]);
      end
    endcase
    if (mq.size() == 0) m_new = ctl[3];
    foreach (units[i]) begin
      mq.push_back(units[i]);
      if (mq.size() > UN) begin
        void'(mq.pop_front());
        m_err = 1'b1;
      end
    end
    if (mq.size() == UN || ctl[2]) begin
      wd = '0;
      foreach (mq[i]) wd = (wd << 8) | 32'(mq[i]);
      exp_dat.push_back(wd);
      exp_ctl.push_back({m_new, ctl[2], 2'(mq.size() - 1)});
      mq.delete();
    end
  endfunction

  // Compare process: every transfer, err every cycle, and hold stability.
  logic [31:0] got_dat[$];
  logic [3:0]  got_ctl[$];
  int          pop_cyc[$];
  bit          hold_prev = 1'b0;
  logic [31:0] prev_dat;
  logic [3:0]  prev_ctl;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      chk("err", 32'(err), 32'(m_err));
      if (hold_prev) begin
        chk("hold_vld", 32'(cmd_vld), 32'd1);
        chk("hold_dat", cmd_dat, prev_dat);
        chk("hold_ctl", 32'(cmd_ctl), 32'(prev_ctl));
      end
      if (cmd_vld && cmd_rdy) begin
        if (exp_dat.size() == 0) begin
          chk("unexpected_word", cmd_dat, 32'hXXXXXXXX);
        end else begin
          chk("cmd_dat", cmd_dat, exp_dat.pop_front());
          chk("cmd_ctl", 32'(cmd_ctl), 32'(exp_ctl.pop_front()));
        end
        got_dat.push_back(cmd_dat);
        got_ctl.push_back(cmd_ctl);
        pop_cyc.push_back(cyc);
      end
      hold_prev = cmd_vld & ~cmd_rdy;
      prev_dat  = cmd_dat;
      prev_ctl  = cmd_ctl;
    end
  end

  task automatic do_rst();
    rst = 1'b1;
    @(posedge clk);
    mq.delete(); exp_dat.delete(); exp_ctl.delete();
    m_err = 1'b0; m_new = 1'b0;
    #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Presents one segment and returns 1ns after the edge that accepts it,
  // leaving que_vld high so consecutive calls are back-to-back.
  task automatic send(input logic [3:0] ctl, input logic [31:0] dat);
    bit r, ok;
    int t;
    que_vld = 1'b1; que_ctl = ctl; que_dat = dat;
    ok = 1'b0; t = 0;
    while (!ok) begin
      r = que_rdy;
      @(posedge clk);
      if (r) begin
        model_accept(ctl, dat);
        ok = 1'b1;
      end
      #1;
      t++;
      if (!ok && t > 200) begin
        chk("send_timeout", 32'(t), 32'd0);
        ok = 1'b1;
      end
    end
  endtask

  task automatic idle();
    que_vld = 1'b0; que_ctl = '0; que_dat = '0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_dat.size() != 0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 100) chk("drain_timeout", 32'(exp_dat.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] spi(logic [7:0] b);
    return {16'h0, b, 8'h0};
  endfunction

  initial begin
    rst = 1'b1; cmd_rdy = 1'b0;
    idle();
    do_rst();
    chk("rst_cmd_vld", 32'(cmd_vld), 32'd0);
    chk("rst_cmd_ctl", 32'(cmd_ctl), 32'd0);
    chk("rst_cmd_dat", cmd_dat, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_que_rdy", 32'(que_rdy), 32'd1);

    // SPI word closed by lst on the 4th segment
    cmd_rdy = 1'b1;
    send(4'h1, spi(8'h11)); send(4'h1, spi(8'h22));
    send(4'h1, spi(8'h33)); send(4'h5, spi(8'h44));
    idle(); drain();
    chk("spi_dat", got_dat[$], 32'h11223344);
    chk("spi_ctl", 32'(got_ctl[$]), 32'b0111);
    chk("spi_err", 32'(err), 32'd0);

    // single quad segment fills the word
    send(4'hB, 32'hFF00FF00);
    idle(); drain();
    chk("quad_dat", got_dat[$], 32'hAAAAAAAA);
    chk("quad_ctl", 32'(got_ctl[$]), 32'b1011);

    // 3-wire partial word flushed by lst
    send(4'h8, 32'h000000A5); send(4'h4, 32'h0000005A);
    idle(); drain();
    chk("3w_dat", got_dat[$], 32'h0000A55A);
    chk("3w_ctl", 32'(got_ctl[$]), 32'b1101);

    // backpressure: second word pends, then both drain back-to-back
    cmd_rdy = 1'b0;
    for (int i = 1; i <= 8; i++) send(4'h1, spi(8'(i)));
    chk("bp_que_rdy_lo", 32'(que_rdy), 32'd0);
    idle();
    @(posedge clk); #1;
    chk("bp_still_lo", 32'(que_rdy), 32'd0);
    chk("bp_out_dat", cmd_dat, 32'h01020304);
    cmd_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_que_rdy_hi", 32'(que_rdy), 32'd1);
    chk("bp_vld2", 32'(cmd_vld), 32'd1);
    chk("bp_dat2", cmd_dat, 32'h05060708);
    drain();
    chk("bp_w1", got_dat[$-1], 32'h01020304);
    chk("bp_w2", got_dat[$], 32'h05060708);
    chk("bp_gap", 32'(pop_cyc[$] - pop_cyc[$-1]), 32'd1);

    // overflow: three SPI units plus a quad segment
    send(4'h1, spi(8'h01)); send(4'h1, spi(8'h02)); send(4'h1, spi(8'h03));
    send(4'h3, 32'h12345678);
    idle(); drain();
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_dat", got_dat[$], 32'h035F16A0);
    chk("ovf_ctl", 32'(got_ctl[$]), 32'b0011);
    repeat (3) @(posedge clk);
    #1;
    chk("ovf_sticky", 32'(err), 32'd1);

    // reset mid-word discards the partial data
    send(4'h1, spi(8'h77)); send(4'h1, spi(8'h88));
    idle();
    do_rst();
    chk("mid_rst_vld", 32'(cmd_vld), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    send(4'h9, spi(8'hDE)); send(4'h1, spi(8'hAD));
    send(4'h1, spi(8'hBE)); send(4'h1, spi(8'hEF));
    idle(); drain();
    chk("post_rst_dat", got_dat[$], 32'hDEADBEEF);
    chk("post_rst_ctl", 32'(got_ctl[$]), 32'b1011);

    // sustained quad throughput: one word per cycle
    send(4'hB, 32'h12345678); send(4'hF, 32'h9ABCDEF0);
    send(4'h3, 32'h0F0F0F0F); send(4'hB, 32'hCAFEF00D);
    send(4'h3, 32'h00FF00FF); send(4'h7, 32'h13579BDF);
    idle(); drain();
    chk("quad_rate", 32'(pop_cyc[$] - pop_cyc[$-5]), 32'd5);
    chk("quad_first", got_dat[$-5], 32'h035F16A0);

    repeat (2) @(posedge clk);
    #1;
    chk("end_idle", 32'(cmd_vld), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
